// File: rtl/bmc_acs_sched.sv
// rtl/bmc_acs_sched.sv - per-symbol sequencer for the Viterbi ACS datapath
module bmc_acs_sched #(
  parameter int NUM_STATES = 64,
  parameter int NUM_PE     = 8,
  parameter int PE_LAT     = 2,
  parameter int TB_LEN     = 32,
  parameter int GW         = 3,
  parameter int TW         = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [1:0]    rx_pair,
  output logic [1:0]    pe_rx_pair,
  output logic          pe_issue,
  output logic [GW-1:0] pe_grp,
  output logic          pe_init,
  output logic          wb_valid,
  output logic [GW-1:0] wb_grp,
  output logic          pm_rd_bank,
  output logic          sv_wr_en,
  output logic [TW-1:0] sv_wr_addr,
  output logic          step_done,
  output logic          tb_req,
  output logic          busy
);

  localparam int G = NUM_STATES / NUM_PE;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

  state_t        state, state_n;
  logic          ready_q;
  logic          first_flag;
  logic [TW-1:0] step_cnt;
  logic [PE_LAT-1:0] wb_v_pipe;
  logic [GW-1:0] wb_g_pipe [PE_LAT];

  logic accept;
  logic last_grp;
  logic last_wb;
  logic step_wrap;

  assign accept    = sym_valid & ready_q;
  assign last_grp  = (pe_grp == GW'(G - 1));
  assign last_wb   = wb_valid & (wb_grp == GW'(G - 1));
  assign step_wrap = (step_cnt == TW'(TB_LEN - 1));

  assign sym_ready  = ready_q;
  assign pe_issue   = (state == ISSUE);
  assign pe_init    = pe_issue & first_flag;
  assign wb_valid   = wb_v_pipe[PE_LAT-1];
  assign wb_grp     = wb_g_pipe[PE_LAT-1];
  assign sv_wr_en   = wb_valid;
  assign sv_wr_addr = step_cnt;
  assign step_done  = (state == SWAP);
  assign tb_req     = step_done & step_wrap;
  assign busy       = (state != IDLE);

  // Next-state logic: accept -> G issue cycles -> drain until last write-back -> bank swap
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ISSUE;
      ISSUE:   if (last_grp) state_n = DRAIN;
      DRAIN:   if (last_wb) state_n = SWAP;
      SWAP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register; ready is registered so it stays low throughout reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == IDLE);
    end
  end

  // Per-step bookkeeping: symbol latch, group counter, bank, step counter, first flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pe_rx_pair <= 2'b00;
      pe_grp     <= '0;
      pm_rd_bank <= 1'b0;
      step_cnt   <= '0;
      first_flag <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pe_rx_pair <= rx_pair;
            if (frame_start) begin
              step_cnt   <= '0;
              first_flag <= 1'b1;
            end
          end
        end
        ISSUE: pe_grp <= last_grp ? '0 : pe_grp + 1'b1;
        SWAP: begin
          pm_rd_bank <= ~pm_rd_bank;
          first_flag <= 1'b0;
          step_cnt   <= step_wrap ? '0 : step_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Issue-to-write-back delay line matching the PE pipeline depth; cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_v_pipe <= '0;
      for (int i = 0; i < PE_LAT; i++) wb_g_pipe[i] <= '0;
    end else begin
      wb_v_pipe[0] <= pe_issue;
      wb_g_pipe[0] <= pe_grp;
      for (int i = 1; i < PE_LAT; i++) begin
        wb_v_pipe[i] <= wb_v_pipe[i-1];
        wb_g_pipe[i] <= wb_g_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_bmc_acs_sched.sv
// tb/tb_bmc_acs_sched.sv - scoreboard bench for bmc_acs_sched
module tb_bmc_acs_sched;

  localparam int NS = 64;
  localparam int NP = 8;
  localparam int PL = 2;
  localparam int TBL = 32;
  localparam int GWL = 3;
  localparam int TWL = 5;
  localparam int G = NS / NP;
  localparam int PERIOD = G + PL + 2;

  typedef struct {
    int pair;
    int init;
    int addr;
    int bank;
    int tb;
    int acc;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_q = 1'b0;
  int   cyc = 0;

  logic           frame_start, sym_valid, sym_ready;
  logic [1:0]     rx_pair, pe_rx_pair;
  logic           pe_issue, pe_init, wb_valid, pm_rd_bank, sv_wr_en;
  logic           step_done, tb_req, busy;
  logic [GWL-1:0] pe_grp, wb_grp;
  logic [TWL-1:0] sv_wr_addr;

  logic       frame_start2, sym_valid2, sym_ready2;
  logic [1:0] rx_pair2, pe_rx_pair2;
  logic       pe_issue2, pe_init2, wb_valid2, pm_rd_bank2, sv_wr_en2;
  logic       step_done2, tb_req2, busy2;
  logic [0:0] pe_grp2, wb_grp2;
  logic [TWL-1:0] sv_wr_addr2;

  int checks = 0;
  int failures = 0;

  step_t exp_q[$];
  int m_cnt = 0;
  int m_first = 1;
  int m_bank = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  bmc_acs_sched #(.NUM_STATES(NS), .NUM_PE(NP), .PE_LAT(PL), .TB_LEN(TBL), .GW(GWL), .TW(TWL)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .rx_pair(rx_pair), .pe_rx_pair(pe_rx_pair), .pe_issue(pe_issue),
    .pe_grp(pe_grp), .pe_init(pe_init), .wb_valid(wb_valid), .wb_grp(wb_grp),
    .pm_rd_bank(pm_rd_bank), .sv_wr_en(sv_wr_en), .sv_wr_addr(sv_wr_addr),
    .step_done(step_done), .tb_req(tb_req), .busy(busy)
  );

  bmc_acs_sched #(.NUM_STATES(64), .NUM_PE(64), .PE_LAT(1), .TB_LEN(TBL), .GW(1), .TW(TWL)) u_dut_g1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start2), .sym_valid(sym_valid2),
    .sym_ready(sym_ready2), .rx_pair(rx_pair2), .pe_rx_pair(pe_rx_pair2), .pe_issue(pe_issue2),
    .pe_grp(pe_grp2), .pe_init(pe_init2), .wb_valid(wb_valid2), .wb_grp(wb_grp2),
    .pm_rd_bank(pm_rd_bank2), .sv_wr_en(sv_wr_en2), .sv_wr_addr(sv_wr_addr2),
    .step_done(step_done2), .tb_req(tb_req2), .busy(busy2)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Offer one symbol, record the model's expectation, and ride out the busy window
  task automatic send(input int p, input int fs, output int acc);
    int n;
    int bad;
    n = 0;
    sym_valid = 1'b1;
    rx_pair = 2'(p);
    frame_start = fs[0];
    while (!sym_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sym_ready) begin
      chk("accept_timeout", 0, 1);
      sym_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (fs != 0) begin
      m_cnt = 0;
      m_first = 1;
    end
    exp_q.push_back('{pair: p, init: m_first, addr: m_cnt, bank: m_bank,
                      tb: (m_cnt == TBL - 1) ? 1 : 0, acc: acc});
    m_cnt = (m_cnt + 1) % TBL;
    m_first = 0;
    m_bank = 1 - m_bank;
    bad = 0;
    for (int k = 1; k < PERIOD; k++) begin
      @(negedge clk);
      if (sym_ready) bad++;
      sym_valid = 1'($urandom_range(0, 1));
      rx_pair = 2'($urandom_range(0, 3));
      frame_start = 1'($urandom_range(0, 1));
    end
    chk("ready_low_while_busy", bad, 0);
    @(negedge clk);
    sym_valid = 1'b0;
    frame_start = 1'b0;
    chk("ready_after_step", int'(sym_ready), 1);
  endtask

  // Monitor / scoreboard for the default-parameter instance
  step_t cur;
  int iss_idx = 0;
  int iss_cyc[$];
  int iss_grp[$];
  int last_wb_cyc = -1;
  always @(negedge clk) begin
    if (!rst_q) begin
      iss_idx = 0;
      iss_cyc.delete();
      iss_grp.delete();
    end else begin
      chk("busy_vs_ready", int'(busy), int'(!sym_ready));
      chk("sv_wr_en_eq_wb", int'(sv_wr_en), int'(wb_valid));
      if (pe_issue) begin
        if (iss_idx == 0) begin
          if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
          else begin
            cur = exp_q.pop_front();
            chk("issue_latency", cyc, cur.acc + 1);
          end
        end
        chk("pe_grp", int'(pe_grp), iss_idx);
        chk("pe_init", int'(pe_init), cur.init);
        chk("pe_rx_pair", int'(pe_rx_pair), cur.pair);
        chk("pm_rd_bank", int'(pm_rd_bank), cur.bank);
        iss_cyc.push_back(cyc);
        iss_grp.push_back(int'(pe_grp));
        iss_idx++;
      end
      if (wb_valid) begin
        if (iss_cyc.size() == 0) chk("stray_wb_valid", 1, 0);
        else begin
          chk("wb_latency", cyc, iss_cyc.pop_front() + PL);
          chk("wb_grp", int'(wb_grp), iss_grp.pop_front());
          chk("sv_wr_addr", int'(sv_wr_addr), cur.addr);
        end
        last_wb_cyc = cyc;
      end
      if (step_done) begin
        chk("step_done_time", cyc, cur.acc + G + PL + 1);
        chk("step_after_last_wb", cyc, last_wb_cyc + 1);
        chk("groups_issued", iss_idx, G);
        chk("tb_req", int'(tb_req), cur.tb);
        iss_idx = 0;
      end else if (tb_req) begin
        chk("tb_req_without_step", 1, 0);
      end
    end
  end

  // Monitor for the single-group, single-latency instance
  int last_acc2 = -1;
  int last_iss2 = -100;
  always @(negedge clk) begin
    if (!rst_q) begin
      last_acc2 = -1;
      last_iss2 = -100;
    end else begin
      if (sym_valid2 && sym_ready2) begin
        if (last_acc2 >= 0) chk("g1_period", cyc - last_acc2, 4);
        last_acc2 = cyc;
      end
      if (pe_issue2) begin
        chk("g1_pe_grp", int'(pe_grp2), 0);
        chk("g1_issue_latency", cyc, last_acc2 + 1);
        last_iss2 = cyc;
      end
      if (wb_valid2) chk("g1_wb_latency", cyc, last_iss2 + 1);
      if (step_done2) chk("g1_step_done_time", cyc, last_acc2 + 3);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc;
    int accs[4];
    int n;
    int stray;
    sym_valid = 1'b0;
    rx_pair = 2'b00;
    frame_start = 1'b0;
    sym_valid2 = 1'b1;
    rx_pair2 = 2'b01;
    frame_start2 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sym_ready", int'(sym_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pe_issue", int'(pe_issue), 0);
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_step_done", int'(step_done), 0);
    chk("rst_tb_req", int'(tb_req), 0);
    chk("rst_pm_rd_bank", int'(pm_rd_bank), 0);
    chk("rst_pe_rx_pair", int'(pe_rx_pair), 0);
    chk("rst_pe_grp", int'(pe_grp), 0);
    chk("rst_wb_grp", int'(wb_grp), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(sym_ready), 1);

    send(2, 1, acc);
    chk("bank_after_first_step", int'(pm_rd_bank), 1);

    for (int i = 0; i < 4; i++) send($urandom_range(0, 3), 0, accs[i]);
    for (int i = 0; i < 3; i++) chk("b2b_period", accs[i+1] - accs[i], PERIOD);

    send($urandom_range(0, 3), 1, acc);
    for (int i = 0; i < 32; i++) send($urandom_range(0, 3), 0, acc);

    send($urandom_range(0, 3), 1, acc);
    for (int i = 0; i < 9; i++) send($urandom_range(0, 3), 0, acc);
    send($urandom_range(0, 3), 1, acc);
    for (int i = 0; i < 32; i++) send($urandom_range(0, 3), 0, acc);

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        sym_valid = 1'b0;
        rx_pair = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
      send($urandom_range(0, 3), ($urandom_range(0, 15) == 0) ? 1 : 0, acc);
    end

    sym_valid = 1'b1;
    rx_pair = 2'b11;
    frame_start = 1'b0;
    n = 0;
    while (!sym_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp_q.push_back('{pair: 3, init: m_first, addr: m_cnt, bank: m_bank,
                      tb: (m_cnt == TBL - 1) ? 1 : 0, acc: cyc});
    @(negedge clk);
    sym_valid = 1'b0;
    n = 0;
    while (!(pe_issue && pe_grp == 3'd4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_grp4", int'(pe_issue && pe_grp == 3'd4), 1);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    m_cnt = 0;
    m_first = 1;
    m_bank = 0;
    chk("abort_pe_issue", int'(pe_issue), 0);
    chk("abort_pe_grp", int'(pe_grp), 0);
    chk("abort_wb_valid", int'(wb_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sym_ready", int'(sym_ready), 0);
    chk("abort_pm_rd_bank", int'(pm_rd_bank), 0);
    chk("abort_pe_rx_pair", int'(pe_rx_pair), 0);
    chk("abort_step_done", int'(step_done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after_release", int'(sym_ready), 1);
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      if (wb_valid || step_done || tb_req) stray++;
      @(negedge clk);
    end
    chk("abort_no_stray_strobes", stray, 0);

    send(1, 0, acc);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
